// File: rtl/alu_pin_driver_if.sv
// Host-facing command/response bundle for alu_pin_driver.
// The master side issues ALU commands and consumes captured results.
interface alu_pin_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [3:0] cmd_b;
  logic [3:0] cmd_op;
  logic       cmd_chk;
  logic [7:0] cmd_exp;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_mismatch;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_chk, cmd_exp, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_mismatch
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_chk, cmd_exp, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_mismatch
  );
endinterface

// File: rtl/alu_pin_driver.sv
// Harness-side pin driver for tt_um_customalu: sequences the ALU reset, applies
// commands to ui_in/uio_in, samples uo_out after LAT cycles and returns the result.
module alu_pin_driver #(
  parameter int unsigned LAT        = 2,
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_pin_driver_if.slave  host,
  output logic [7:0]       dut_ui_in,
  output logic [7:0]       dut_uio_in,
  output logic             dut_ena,
  output logic             dut_rst_n,
  input  logic [7:0]       dut_uo_out,
  input  logic [7:0]       dut_uio_oe,
  output logic [CNT_W-1:0] cmd_count,
  output logic [CNT_W-1:0] err_count,
  output logic             oe_err
);

  // Shared counter covers both the reset stretch (<=255) and the latency (<=15).
  localparam int unsigned CTR_W = 8;

  if (LAT < 1 || LAT > 15) begin : g_bad_lat
    $error("alu_pin_driver: LAT must be in 1..15");
  end
  if (RST_CYCLES < 1 || RST_CYCLES > 255) begin : g_bad_rst_cycles
    $error("alu_pin_driver: RST_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {
    RST_DUT = 2'd0,
    IDLE    = 2'd1,
    WAIT    = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CTR_W-1:0] ctr, ctr_nxt;

  logic             cmd_ready_q, cmd_ready_nxt;
  logic             rsp_valid_q, rsp_valid_nxt;
  logic [7:0]       rsp_data_q, rsp_data_nxt;
  logic             rsp_mismatch_q, rsp_mismatch_nxt;
  logic             chk_q, chk_nxt;
  logic [7:0]       exp_q, exp_nxt;

  logic [7:0]       ui_nxt, uio_nxt;
  logic             ena_nxt, rst_n_nxt;
  logic [CNT_W-1:0] cmd_count_nxt, err_count_nxt;
  logic             oe_err_nxt;
  logic             mismatch_c;

  assign host.cmd_ready    = cmd_ready_q;
  assign host.rsp_valid    = rsp_valid_q;
  assign host.rsp_data     = rsp_data_q;
  assign host.rsp_mismatch = rsp_mismatch_q;

  assign mismatch_c = chk_q && (dut_uo_out != exp_q);

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_nxt        = state;
    ctr_nxt          = ctr;
    cmd_ready_nxt    = cmd_ready_q;
    rsp_valid_nxt    = rsp_valid_q;
    rsp_data_nxt     = rsp_data_q;
    rsp_mismatch_nxt = rsp_mismatch_q;
    chk_nxt          = chk_q;
    exp_nxt          = exp_q;
    ui_nxt           = dut_ui_in;
    uio_nxt          = dut_uio_in;
    ena_nxt          = dut_ena;
    rst_n_nxt        = dut_rst_n;
    cmd_count_nxt    = cmd_count;
    err_count_nxt    = err_count;
    oe_err_nxt       = oe_err;

    case (state)
      RST_DUT: begin
        rst_n_nxt = 1'b0;
        ena_nxt   = 1'b0;
        if (ctr == CTR_W'(RST_CYCLES - 1)) begin
          rst_n_nxt     = 1'b1;
          ena_nxt       = 1'b1;
          cmd_ready_nxt = 1'b1;
          ctr_nxt       = '0;
          state_nxt     = IDLE;
        end else begin
          ctr_nxt = ctr + CTR_W'(1);
        end
      end

      IDLE: begin
        if (host.cmd_valid && cmd_ready_q) begin
          ui_nxt        = host.cmd_a;
          uio_nxt       = {host.cmd_op, host.cmd_b};
          chk_nxt       = host.cmd_chk;
          exp_nxt       = host.cmd_exp;
          cmd_count_nxt = cmd_count + CNT_W'(1);
          cmd_ready_nxt = 1'b0;
          ctr_nxt       = CTR_W'(1);
          state_nxt     = WAIT;
        end
      end

      WAIT: begin
        if (ctr == CTR_W'(LAT)) begin
          rsp_data_nxt     = dut_uo_out;
          rsp_mismatch_nxt = mismatch_c;
          if (mismatch_c && (err_count != '1)) begin
            err_count_nxt = err_count + CNT_W'(1);
          end
          if (dut_uio_oe != 8'h00) begin
            oe_err_nxt = 1'b1;
          end
          rsp_valid_nxt = 1'b1;
          ctr_nxt       = '0;
          state_nxt     = RESP;
        end else begin
          ctr_nxt = ctr + CTR_W'(1);
        end
      end

      RESP: begin
        if (host.rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          cmd_ready_nxt = 1'b1;
          state_nxt     = IDLE;
        end
      end

      default: begin
        state_nxt = RST_DUT;
        ctr_nxt   = '0;
      end
    endcase
  end

  // State and registered outputs; rst drops everything including the ALU reset line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= RST_DUT;
      ctr            <= '0;
      cmd_ready_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= 8'h00;
      rsp_mismatch_q <= 1'b0;
      chk_q          <= 1'b0;
      exp_q          <= 8'h00;
      dut_ui_in      <= 8'h00;
      dut_uio_in     <= 8'h00;
      dut_ena        <= 1'b0;
      dut_rst_n      <= 1'b0;
      cmd_count      <= '0;
      err_count      <= '0;
      oe_err         <= 1'b0;
    end else begin
      state          <= state_nxt;
      ctr            <= ctr_nxt;
      cmd_ready_q    <= cmd_ready_nxt;
      rsp_valid_q    <= rsp_valid_nxt;
      rsp_data_q     <= rsp_data_nxt;
      rsp_mismatch_q <= rsp_mismatch_nxt;
      chk_q          <= chk_nxt;
      exp_q          <= exp_nxt;
      dut_ui_in      <= ui_nxt;
      dut_uio_in     <= uio_nxt;
      dut_ena        <= ena_nxt;
      dut_rst_n      <= rst_n_nxt;
      cmd_count      <= cmd_count_nxt;
      err_count      <= err_count_nxt;
      oe_err         <= oe_err_nxt;
    end
  end

endmodule

// File: tb/tb_alu_pin_driver.sv
// Bench for alu_pin_driver: behavioural ALU on the pins plus a transaction-level
// model of responses, latency and counters. Narrow counters make wrap/saturation reachable.
module tb_alu_pin_driver;

  localparam int unsigned LAT        = 2;
  localparam int unsigned RST_CYCLES = 4;
  localparam int unsigned CNT_W      = 4;
  localparam int          CNT_MAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_pin_driver_if bus ();

  logic [7:0]       dut_ui_in, dut_uio_in, dut_uo_out, dut_uio_oe;
  logic             dut_ena, dut_rst_n;
  logic [CNT_W-1:0] cmd_count, err_count;
  logic             oe_err;
  logic [7:0]       oe_drive = 8'h00;

  alu_pin_driver #(.LAT(LAT), .RST_CYCLES(RST_CYCLES), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .host       (bus),
    .dut_ui_in  (dut_ui_in),
    .dut_uio_in (dut_uio_in),
    .dut_ena    (dut_ena),
    .dut_rst_n  (dut_rst_n),
    .dut_uo_out (dut_uo_out),
    .dut_uio_oe (dut_uio_oe),
    .cmd_count  (cmd_count),
    .err_count  (err_count),
    .oe_err     (oe_err)
  );

  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [3:0] b,
                                        input logic [3:0] op);
    case (op)
      4'h0:    return a;
      4'h1:    return a + {4'h0, b};
      4'h2:    return a - {4'h0, b};
      4'h3:    return a ^ {b, b};
      4'h4:    return a & {4'hF, b};
      default: return {a[3:0], b};
    endcase
  endfunction

  // Behavioural ALU: responds to the pins only while enabled and out of reset.
  always_comb begin
    dut_uo_out = (dut_rst_n && dut_ena) ? alu_fn(dut_ui_in, dut_uio_in[3:0], dut_uio_in[7:4]) : 8'h00;
    dut_uio_oe = oe_drive;
  end

  int tests = 0;
  int fails = 0;
  int exp_cmd = 0;
  int exp_err = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic model_accept(input logic [7:0] a, input logic [3:0] b, input logic [3:0] op,
                              input logic chk, input logic [7:0] e);
    exp_cmd = (exp_cmd + 1) & CNT_MAX;
    if (chk && (alu_fn(a, b, op) != e) && (exp_err < CNT_MAX)) exp_err++;
  endtask

  // Drive one command and wait (bounded) for its accept edge; returns at accept edge + #1.
  task automatic send_cmd(input logic [7:0] a, input logic [3:0] b, input logic [3:0] op,
                          input logic chk, input logic [7:0] e, output bit ok);
    bit acc;
    ok = 0;
    bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = op; bus.cmd_chk = chk; bus.cmd_exp = e;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      acc = bus.cmd_ready;
      @(posedge clk); #1;
      if (acc) begin ok = 1; break; end
    end
    bus.cmd_valid = 1'b0;
    if (ok) model_accept(a, b, op, chk, e);
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.rsp_valid) begin ok = 1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic ack_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic run_quiet(input logic [7:0] a, input logic [3:0] b, input logic [3:0] op,
                           input logic chk, input logic [7:0] e);
    bit ok1, ok2;
    send_cmd(a, b, op, chk, e, ok1);
    wait_rsp(ok2);
    tests++;
    if (!(ok1 && ok2)) begin
      fails++;
      $display("FAIL run_timeout accepted=%0b responded=%0b required=1/1", ok1, ok2);
    end
    ack_rsp();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    exp_cmd = 0;
    exp_err = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      tests++;
      if ({dut_rst_n, dut_ena, dut_ui_in, dut_uio_in, bus.cmd_ready, bus.rsp_valid,
           bus.rsp_data, bus.rsp_mismatch, cmd_count, err_count, oe_err} !== '0) begin
        fails++;
        $display("FAIL reset_values rst_n=%b ena=%b ui=%h uio=%h rdy=%b vld=%b data=%h mm=%b cc=%h ec=%h oe=%b required all 0",
                 dut_rst_n, dut_ena, dut_ui_in, dut_uio_in, bus.cmd_ready, bus.rsp_valid,
                 bus.rsp_data, bus.rsp_mismatch, cmd_count, err_count, oe_err);
      end
    end
    rst = 1'b0;
    for (int e = 1; e <= RST_CYCLES; e++) begin
      @(posedge clk); #1;
      tests++;
      if (e < RST_CYCLES) begin
        if ({dut_rst_n, dut_ena, bus.cmd_ready} !== 3'b000) begin
          fails++;
          $display("FAIL reset_hold edge=%0d rst_n/ena/ready=%b required 000", e, {dut_rst_n, dut_ena, bus.cmd_ready});
        end
      end else begin
        if ({dut_rst_n, dut_ena, bus.cmd_ready, bus.rsp_valid} !== 4'b1110) begin
          fails++;
          $display("FAIL reset_release edge=%0d rst_n/ena/ready/vld=%b required 1110", e,
                   {dut_rst_n, dut_ena, bus.cmd_ready, bus.rsp_valid});
        end
      end
    end
  endtask

  task automatic test_single();
    bit ok;
    send_cmd(8'h10, 4'h3, 4'h1, 1'b1, 8'h13, ok);
    tests++;
    if (!ok || dut_ui_in !== 8'h10 || dut_uio_in !== 8'h13 || bus.rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_pins ok=%0b ui=%h uio=%h vld=%b required 1/10/13/0", ok, dut_ui_in, dut_uio_in, bus.rsp_valid);
    end
    @(posedge clk); #1;
    tests++;
    if (bus.rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_early_valid vld=%b required 0 at T+1", bus.rsp_valid);
    end
    @(posedge clk); #1;
    tests++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h13 || bus.rsp_mismatch !== 1'b0 ||
        cmd_count !== CNT_W'(1) || err_count !== CNT_W'(0)) begin
      fails++;
      $display("FAIL single_rsp vld=%b data=%h mm=%b cc=%h ec=%h required 1/13/0/1/0",
               bus.rsp_valid, bus.rsp_data, bus.rsp_mismatch, cmd_count, err_count);
    end
    ack_rsp();
  endtask

  task automatic test_mismatch();
    bit ok1, ok2;
    for (int k = 1; k <= 2; k++) begin
      send_cmd(8'h10, 4'h3, 4'h1, 1'b1, 8'h14, ok1);
      wait_rsp(ok2);
      tests++;
      if (!(ok1 && ok2) || bus.rsp_data !== 8'h13 || bus.rsp_mismatch !== 1'b1 ||
          err_count !== CNT_W'(exp_err) || exp_err != k) begin
        fails++;
        $display("FAIL mismatch_%0d data=%h mm=%b ec=%h required 13/1/%0d", k, bus.rsp_data,
                 bus.rsp_mismatch, err_count, k);
      end
      ack_rsp();
    end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    logic [7:0] d0, r2;
    send_cmd(8'h22, 4'h4, 4'h1, 1'b0, 8'h00, ok1);
    wait_rsp(ok2);
    d0 = bus.rsp_data;
    tests++;
    if (!(ok1 && ok2) || d0 !== 8'h26) begin
      fails++;
      $display("FAIL bp_first data=%h required 26", d0);
    end
    r2 = alu_fn(8'h5A, 4'h7, 4'h2);
    bus.cmd_a = 8'h5A; bus.cmd_b = 4'h7; bus.cmd_op = 4'h2; bus.cmd_chk = 1'b1; bus.cmd_exp = r2;
    bus.cmd_valid = 1'b1;
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== d0 || bus.cmd_ready !== 1'b0 || dut_ui_in !== 8'h22) begin
        fails++;
        $display("FAIL bp_hold cycle=%0d vld=%b data=%h rdy=%b ui=%h required 1/%h/0/22",
                 c, bus.rsp_valid, bus.rsp_data, bus.cmd_ready, dut_ui_in, d0);
      end
    end
    ack_rsp();
    tests++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || dut_ui_in !== 8'h22) begin
      fails++;
      $display("FAIL bp_handshake vld=%b rdy=%b ui=%h required 0/1/22", bus.rsp_valid, bus.cmd_ready, dut_ui_in);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    model_accept(8'h5A, 4'h7, 4'h2, 1'b1, r2);
    tests++;
    if (bus.cmd_ready !== 1'b0 || dut_ui_in !== 8'h5A || dut_uio_in !== 8'h27 || cmd_count !== CNT_W'(exp_cmd)) begin
      fails++;
      $display("FAIL bp_next_accept rdy=%b ui=%h uio=%h cc=%h required 0/5a/27/%h",
               bus.cmd_ready, dut_ui_in, dut_uio_in, cmd_count, exp_cmd);
    end
    wait_rsp(ok2);
    tests++;
    if (!ok2 || bus.rsp_data !== r2 || bus.rsp_mismatch !== 1'b0) begin
      fails++;
      $display("FAIL bp_second_rsp data=%h mm=%b required %h/0", bus.rsp_data, bus.rsp_mismatch, r2);
    end
    ack_rsp();
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] a, e, r;
    logic [3:0] b, op;
    logic chk, mm;
    for (int n = 0; n < 30; n++) begin
      a   = 8'($urandom_range(0, 255));
      b   = 4'($urandom_range(0, 15));
      op  = 4'($urandom_range(0, 15));
      chk = 1'($urandom_range(0, 1));
      r   = alu_fn(a, b, op);
      e   = ($urandom_range(0, 1) == 1) ? r : 8'($urandom_range(0, 255));
      mm  = chk && (r != e);
      send_cmd(a, b, op, chk, e, ok);
      tests++;
      if (!ok || dut_ui_in !== a || dut_uio_in !== {op, b}) begin
        fails++;
        $display("FAIL rand_pins n=%0d ui=%h uio=%h required %h/%h", n, dut_ui_in, dut_uio_in, a, {op, b});
      end
      for (int k = 1; k < LAT; k++) begin
        @(posedge clk); #1;
        tests++;
        if (bus.rsp_valid !== 1'b0) begin
          fails++;
          $display("FAIL rand_early n=%0d k=%0d vld=%b required 0", n, k, bus.rsp_valid);
        end
      end
      @(posedge clk); #1;
      tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== r || bus.rsp_mismatch !== mm ||
          cmd_count !== CNT_W'(exp_cmd) || err_count !== CNT_W'(exp_err)) begin
        fails++;
        $display("FAIL rand_rsp n=%0d vld=%b data=%h mm=%b cc=%h ec=%h required 1/%h/%b/%h/%h",
                 n, bus.rsp_valid, bus.rsp_data, bus.rsp_mismatch, cmd_count, err_count,
                 r, mm, exp_cmd, exp_err);
      end
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      ack_rsp();
    end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    send_cmd(8'hA5, 4'h6, 4'h3, 1'b1, 8'h00, ok);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    tests++;
    if (!ok || dut_rst_n !== 1'b0 || dut_ena !== 1'b0 || dut_ui_in !== 8'h00 || dut_uio_in !== 8'h00 ||
        cmd_count !== CNT_W'(0) || bus.rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL midwait_async ok=%0b rst_n=%b ena=%b ui=%h uio=%h cc=%h vld=%b required 1/0/0/00/00/0/0",
               ok, dut_rst_n, dut_ena, dut_ui_in, dut_uio_in, cmd_count, bus.rsp_valid);
    end
    @(posedge clk); #1;
    test_reset();
    tests++;
    if (bus.rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL midwait_dropped vld=%b required 0", bus.rsp_valid);
    end
  endtask

  task automatic test_oe_and_counters();
    bit ok;
    tests++;
    if (oe_err !== 1'b0) begin
      fails++;
      $display("FAIL oe_initial oe_err=%b required 0", oe_err);
    end
    oe_drive = 8'h01;
    send_cmd(8'h01, 4'h1, 4'h0, 1'b0, 8'h00, ok);
    wait_rsp(ok);
    oe_drive = 8'h00;
    tests++;
    if (!ok || oe_err !== 1'b1) begin
      fails++;
      $display("FAIL oe_set oe_err=%b required 1", oe_err);
    end
    ack_rsp();
    run_quiet(8'h30, 4'h2, 4'h1, 1'b0, 8'h00);
    tests++;
    if (oe_err !== 1'b1) begin
      fails++;
      $display("FAIL oe_sticky oe_err=%b required 1", oe_err);
    end
    for (int i = 0; i < 20 && exp_err < CNT_MAX; i++) run_quiet(8'h10, 4'h3, 4'h1, 1'b1, 8'h14);
    tests++;
    if (err_count !== CNT_W'(CNT_MAX)) begin
      fails++;
      $display("FAIL err_reach_max ec=%h required %h", err_count, CNT_MAX);
    end
    run_quiet(8'h10, 4'h3, 4'h1, 1'b1, 8'h14);
    tests++;
    if (err_count !== CNT_W'(CNT_MAX) || bus.rsp_mismatch !== 1'b1) begin
      fails++;
      $display("FAIL err_saturate ec=%h mm=%b required %h/1", err_count, bus.rsp_mismatch, CNT_MAX);
    end
    for (int i = 0; i < 20 && exp_cmd != CNT_MAX; i++) run_quiet(8'h40, 4'h1, 4'h1, 1'b0, 8'h00);
    tests++;
    if (cmd_count !== CNT_W'(CNT_MAX)) begin
      fails++;
      $display("FAIL cmd_reach_max cc=%h required %h", cmd_count, CNT_MAX);
    end
    run_quiet(8'h40, 4'h1, 4'h1, 1'b0, 8'h00);
    tests++;
    if (cmd_count !== CNT_W'(0) || exp_cmd != 0) begin
      fails++;
      $display("FAIL cmd_wrap cc=%h required 0", cmd_count);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = 8'h00;
    bus.cmd_b     = 4'h0;
    bus.cmd_op    = 4'h0;
    bus.cmd_chk   = 1'b0;
    bus.cmd_exp   = 8'h00;
    bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_mismatch();
    test_back_to_back();
    test_random();
    test_reset_mid_wait();
    test_oe_and_counters();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_pin_driver.md
Name: alu_pin_driver

Overview:
- Host-side driver for the tt_um_customalu pin interface. It plays the harness side of the pins: drives ui_in, uio_in, ena and rst_n into the ALU, then samples uo_out and uio_oe.
- Accepts ALU commands on a valid/ready port and sequences the ALU reset.
- Applies operands and opcode, waits a fixed pipeline latency, captures the result and returns it on a valid/ready response port.
- Optionally compares the result against an expected value and keeps error statistics.

Parameters:
- LAT, 2, cycles from command accept to uo_out sample; legal range 1..15.
- RST_CYCLES, 4, cycles dut_rst_n is held low after rst deasserts; legal range 1..255.
- CNT_W, 16, width of cmd_count and err_count.

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  driver can accept a command
- cmd_a  in  8  operand A
- cmd_b  in  4  operand B
- cmd_op  in  4  ALU opcode
- cmd_chk  in  1  compare the result against cmd_exp
- cmd_exp  in  8  expected result
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_data  out  8  captured uo_out
- rsp_mismatch  out  1  cmd_chk was set and rsp_data != cmd_exp
- dut_ui_in  out  8  to ALU ui_in
- dut_uio_in  out  8  to ALU uio_in
- dut_ena  out  1  to ALU ena
- dut_rst_n  out  1  to ALU rst_n (active-low)
- dut_uo_out  in  8  from ALU uo_out
- dut_uio_oe  in  8  from ALU uio_oe
- cmd_count  out  CNT_W  commands accepted; wraps
- err_count  out  CNT_W  mismatches; saturates at all-ones
- oe_err  out  1  sticky flag: uio_oe was nonzero at a sample point

Behaviour:
- All outputs are registered.
- Reset values (rst high, applied asynchronously):
  - dut_rst_n=0, dut_ena=0, dut_ui_in=0, dut_uio_in=0
  - cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_mismatch=0
  - cmd_count=0, err_count=0, oe_err=0
  - state=RST_DUT, counter=0
- Pin mapping:
  - dut_ui_in = cmd_a
  - dut_uio_in = {cmd_op, cmd_b}
- States:
  - RST_DUT:
    - dut_rst_n=0, dut_ena=0.
    - Counts RST_CYCLES clocks after rst falls.
    - On the final count: dut_rst_n<=1, dut_ena<=1, cmd_ready<=1, go to IDLE.
  - IDLE:
    - cmd_ready=1.
    - On a clock edge with cmd_valid&&cmd_ready:
      - latch the pins and cmd_chk/cmd_exp;
      - cmd_count+1;
      - cmd_ready<=0; counter<=1;
      - go to WAIT.
  - WAIT:
    - Counter increments each cycle.
    - At the edge where the counter equals LAT:
      - sample dut_uo_out into rsp_data;
      - rsp_mismatch<=cmd_chk&&(dut_uo_out!=cmd_exp);
      - if that mismatch is set, err_count+1, saturating;
      - if dut_uio_oe!=0, oe_err<=1;
      - rsp_valid<=1; go to RESP.
  - RESP:
    - rsp_valid, rsp_data and rsp_mismatch are held stable until rsp_valid&&rsp_ready.
    - On that handshake: rsp_valid<=0, cmd_ready<=1, go to IDLE.
    - Minimum spacing between accepts is LAT+2 cycles.
- Latency:
  - A command accepted at edge T has its pins visible after edge T.
  - uo_out is sampled at edge T+LAT; rsp_valid is high after that edge.
- Pins hold their last command values while in RESP and IDLE; they return to 0 only on reset.
- cmd_valid in WAIT/RESP is ignored (cmd_ready=0). No command is queued or lost; the host holds cmd_valid.
- rsp_ready while rsp_valid=0 has no effect.
- cmd_count wraps from all-ones to 0. err_count sticks at all-ones.
- oe_err clears only on rst.
- Reset asserted mid-WAIT or mid-RESP: all state is abandoned, the response is dropped and dut_rst_n falls immediately. After rst falls, the full RST_CYCLES sequence is repeated.
- LAT is fixed at elaboration. An implementation must flag LAT=0 via an elaboration-time assertion.

Test Plan:
1. Reset sequence, RST_CYCLES=4.
   - rst high for 3 cycles, then low.
   - Required: dut_rst_n=0 and cmd_ready=0 for exactly 4 edges; then dut_rst_n=1, dut_ena=1, cmd_ready=1.
2. Single command, LAT=2, ALU model returns A+B.
   - Command a=0x10, b=0x3, op=0x1, chk=1, exp=0x13, accepted at edge T.
   - Required: dut_ui_in=0x10 and dut_uio_in=0x13 after T.
   - Required: rsp_valid=1 after T+2, rsp_data=0x13, rsp_mismatch=0, cmd_count=1.
3. Mismatch.
   - Same command with exp=0x14.
   - Required: rsp_mismatch=1, err_count increments 0→1; a second mismatch gives 2.
4. Backpressure.
   - rsp_ready=0 for 5 cycles with cmd_valid held high.
   - Required: rsp_valid and rsp_data stable; cmd_ready stays 0; the new command is accepted exactly one edge after the rsp handshake.
5. Reset mid-WAIT.
   - Assert rst one cycle after accept.
   - Required: rsp_valid never rises; pins=0; dut_rst_n=0 immediately (asynchronous); cmd_count=0; the reset sequence repeats.
6. uio_oe and counters.
   - Model drives dut_uio_oe=0x01 at a sample point.
   - Required: oe_err=1 and it persists across later commands.
   - Preload cmd_count to 0xFFFF: one accept gives 0x0000.
   - err_count at 0xFFFF plus a mismatch stays 0xFFFF.
